hazard_scoreboard_unit: RTL and testbench

//  Parametrised hazard control for the 5-stage core; branches and JALR resolve in ID.
//  Per-register countdown scoreboard tracks in-flight ALU, MUL and load writers.

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 77 +++++++
 rtl/hazard_scoreboard_unit.sv | 99 +++++++++
 tb/tb_hazard_scoreboard_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and latency helpers for the hazard scoreboard.
// The lat_cnt_t width shown here is for the default latencies; modules derive their own.
package hazard_pkg;

    localparam int unsigned ALU_LAT_DEF  = 1;
    localparam int unsigned MUL_LAT_DEF  = 3;
    localparam int unsigned LOAD_LAT_DEF = 2;

    typedef logic [4:0] reg_idx_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // At least one bit, even if every latency is zero.
    function automatic int unsigned cnt_width(input int unsigned alu_lat,
                                              input int unsigned mul_lat,
                                              input int unsigned load_lat);
        int unsigned w;
        w = $clog2(max3(alu_lat, mul_lat, load_lat) + 1);
        return (w == 0) ? 1 : w;
    endfunction

    localparam int unsigned CNT_W = cnt_width(ALU_LAT_DEF, MUL_LAT_DEF, LOAD_LAT_DEF);

    typedef logic [CNT_W-1:0] lat_cnt_t;

    function automatic int unsigned issue_lat(input logic mem_read, input logic is_mul,
                                              input int unsigned alu_lat,
                                              input int unsigned mul_lat,
                                              input int unsigned load_lat);
        if (mem_read) return load_lat;
        if (is_mul)   return mul_lat;
        return alu_lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown array: cycles until each register's writer result is forwardable.
// Answers "ready now" (count 0) and "ready via EX forwarding" (count <= 1) for two sources.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
    parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] rd,
    input  logic       mem_read,
    input  logic       is_mul,
    input  logic       advance,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic       rs1_now,
    output logic       rs1_fwd,
    output logic       rs2_now,
    output logic       rs2_fwd
);

    localparam int unsigned CntW = cnt_width(ALU_LAT, MUL_LAT, LOAD_LAT);
    typedef logic [CntW-1:0] cnt_t;

    cnt_t cnt_q [NUM_REGS];
    cnt_t cnt_d [NUM_REGS];
    cnt_t load_val;
    cnt_t rs1_cnt;
    cnt_t rs2_cnt;

    assign load_val = cnt_t'(issue_lat(mem_read, is_mul, ALU_LAT, MUL_LAT, LOAD_LAT));

    // A fresh load overrides the decrement of the same entry; x0 is never tracked.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (advance && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - cnt_t'(1);
            end
            if (load && (rd == reg_idx_t'(r))) begin
                cnt_d[r] = load_val;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rs1 == reg_idx_t'(r)) rs1_cnt = cnt_q[r];
            if (rs2 == reg_idx_t'(r)) rs2_cnt = cnt_q[r];
        end
    end

    assign rs1_now = (rs1_cnt == '0);
    assign rs1_fwd = (rs1_cnt <= cnt_t'(1));
    assign rs2_now = (rs2_cnt == '0);
    assign rs2_fwd = (rs2_cnt <= cnt_t'(1));

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard control for the 5-stage core: ID stall, EX bubble, flush and mispredict.
// Define HAZARD_PERF_EN to build the stall/flush performance counters; otherwise they read 0.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
    parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_Valid,
    input  logic [4:0]  ID_Rs1,
    input  logic [4:0]  ID_Rs2,
    input  logic        ID_UsesRs1,
    input  logic        ID_UsesRs2,
    input  logic        ID_RegWrite,
    input  logic [4:0]  ID_Rd,
    input  logic        ID_MemRead,
    input  logic        ID_IsMul,
    input  logic        ID_AttemptBranch,
    input  logic        ID_IsJALR,
    input  logic        ID_BranchTaken,
    input  logic        ID_PredictBranchTaken,
    input  logic        MEM_Wait,
    output logic        ID_Stall,
    output logic        EX_Bubble,
    output logic        flush,
    output logic        mispredict,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    logic rs1_now, rs1_fwd, rs2_now, rs2_fwd;
    logic rs1_ok, rs2_ok;
    logic resolves_in_id;
    logic stall;
    logic issue;
    logic load;

    hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ALU_LAT  (ALU_LAT),
        .MUL_LAT  (MUL_LAT),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .rd       (ID_Rd),
        .mem_read (ID_MemRead),
        .is_mul   (ID_IsMul),
        .advance  (~MEM_Wait),
        .rs1      (ID_Rs1),
        .rs2      (ID_Rs2),
        .rs1_now  (rs1_now),
        .rs1_fwd  (rs1_fwd),
        .rs2_now  (rs2_now),
        .rs2_fwd  (rs2_fwd)
    );

    // Branches and JALR compare in ID, so they cannot take the EX forward path.
    always_comb begin
        resolves_in_id = ID_AttemptBranch | ID_IsJALR;
        rs1_ok = ~ID_UsesRs1 | (resolves_in_id ? rs1_now : rs1_fwd);
        rs2_ok = ~ID_UsesRs2 | (resolves_in_id ? rs2_now : rs2_fwd);
        stall  = rst & ID_Valid & (~(rs1_ok & rs2_ok) | MEM_Wait);
        issue  = rst & ID_Valid & ~stall;
        load   = issue & ID_RegWrite & (ID_Rd != '0);

        ID_Stall   = stall;
        EX_Bubble  = stall & ~MEM_Wait;
        mispredict = issue & ID_AttemptBranch & (ID_BranchTaken != ID_PredictBranchTaken);
        flush      = mispredict | (issue & ID_IsJALR);
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: expected outputs queued per driven cycle,
// popped and compared on the falling edge.
module tb_hazard_scoreboard_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       we;
        logic [4:0] rd;
        logic       mem_rd;
        logic       mul;
        logic       br;
        logic       jalr;
        logic       taken;
        logic       pred;
    } instr_t;

    // {stall, bubble, flush, mispredict}
    typedef logic [3:0] exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ID_Valid = 1'b0;
    logic [4:0]  ID_Rs1 = '0;
    logic [4:0]  ID_Rs2 = '0;
    logic        ID_UsesRs1 = 1'b0;
    logic        ID_UsesRs2 = 1'b0;
    logic        ID_RegWrite = 1'b0;
    logic [4:0]  ID_Rd = '0;
    logic        ID_MemRead = 1'b0;
    logic        ID_IsMul = 1'b0;
    logic        ID_AttemptBranch = 1'b0;
    logic        ID_IsJALR = 1'b0;
    logic        ID_BranchTaken = 1'b0;
    logic        ID_PredictBranchTaken = 1'b0;
    logic        MEM_Wait = 1'b0;
    logic        ID_Stall;
    logic        EX_Bubble;
    logic        flush;
    logic        mispredict;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    exp_t        exp_q [$];
    exp_t        e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned mdl_stall = 0;
    int unsigned mdl_flush = 0;
    string       phase = "init";

    hazard_scoreboard_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .ID_Valid              (ID_Valid),
        .ID_Rs1                (ID_Rs1),
        .ID_Rs2                (ID_Rs2),
        .ID_UsesRs1            (ID_UsesRs1),
        .ID_UsesRs2            (ID_UsesRs2),
        .ID_RegWrite           (ID_RegWrite),
        .ID_Rd                 (ID_Rd),
        .ID_MemRead            (ID_MemRead),
        .ID_IsMul              (ID_IsMul),
        .ID_AttemptBranch      (ID_AttemptBranch),
        .ID_IsJALR             (ID_IsJALR),
        .ID_BranchTaken        (ID_BranchTaken),
        .ID_PredictBranchTaken (ID_PredictBranchTaken),
        .MEM_Wait              (MEM_Wait),
        .ID_Stall              (ID_Stall),
        .EX_Bubble             (EX_Bubble),
        .flush                 (flush),
        .mispredict            (mispredict),
        .perf_stall_cnt        (perf_stall_cnt),
        .perf_flush_cnt        (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    function automatic instr_t f_nop();
        instr_t i = '0;
        return i;
    endfunction

    function automatic instr_t f_alu(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        instr_t i = '0;
        i.valid = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1;
        i.we = 1'b1; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t f_load(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i = '0;
        i.valid = 1'b1; i.rs1 = rs1; i.u1 = 1'b1; i.we = 1'b1; i.rd = rd; i.mem_rd = 1'b1;
        return i;
    endfunction

    function automatic instr_t f_mul(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
        instr_t i = f_alu(rd, rs1, rs2);
        i.mul = 1'b1;
        return i;
    endfunction

    function automatic instr_t f_br(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic taken, input logic pred);
        instr_t i = '0;
        i.valid = 1'b1; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1;
        i.br = 1'b1; i.taken = taken; i.pred = pred;
        return i;
    endfunction

    function automatic instr_t f_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t i = '0;
        i.valid = 1'b1; i.rs1 = rs1; i.u1 = 1'b1; i.we = 1'b1; i.rd = rd; i.jalr = 1'b1;
        return i;
    endfunction

    // Drive one ID cycle just after the rising edge and queue what the outputs must be.
    task automatic step(input instr_t i, input exp_t ex, input logic mw, input logic rv);
        @(posedge clk);
        #1;
        rst                   = rv;
        MEM_Wait              = mw;
        ID_Valid              = i.valid;
        ID_Rs1                = i.rs1;
        ID_Rs2                = i.rs2;
        ID_UsesRs1            = i.u1;
        ID_UsesRs2            = i.u2;
        ID_RegWrite           = i.we;
        ID_Rd                 = i.rd;
        ID_MemRead            = i.mem_rd;
        ID_IsMul              = i.mul;
        ID_AttemptBranch      = i.br;
        ID_IsJALR             = i.jalr;
        ID_BranchTaken        = i.taken;
        ID_PredictBranchTaken = i.pred;
        exp_q.push_back(ex);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(f_nop(), 4'b0000, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (!rst) begin
                mdl_stall = 0;
                mdl_flush = 0;
            end
            check("stall",      {31'd0, ID_Stall},   {31'd0, e[3]});
            check("bubble",     {31'd0, EX_Bubble},  {31'd0, e[2]});
            check("flush",      {31'd0, flush},      {31'd0, e[1]});
            check("mispredict", {31'd0, mispredict}, {31'd0, e[0]});
`ifdef HAZARD_PERF_EN
            check("perf_stall", perf_stall_cnt, mdl_stall);
            check("perf_flush", perf_flush_cnt, mdl_flush);
`else
            check("perf_stall", perf_stall_cnt, 32'd0);
            check("perf_flush", perf_flush_cnt, 32'd0);
`endif
            if (rst) begin
                mdl_stall += 32'(e[3]);
                mdl_flush += 32'(e[1]);
            end
        end
    end

    initial begin
        phase = "reset";
        step(f_alu(5'd1, 5'd2, 5'd3), 4'b0000, 1'b0, 1'b0);
        step(f_br(5'd1, 5'd0, 1'b1, 1'b0), 4'b0000, 1'b1, 1'b0);
        drain(1);

        phase = "load_alu";
        step(f_load(5'd3, 5'd1), 4'b0000, 1'b0, 1'b1);
        step(f_alu(5'd5, 5'd3, 5'd2), 4'b1100, 1'b0, 1'b1);
        step(f_alu(5'd5, 5'd3, 5'd2), 4'b0000, 1'b0, 1'b1);
        drain(3);

        phase = "load_branch";
        step(f_load(5'd4, 5'd1), 4'b0000, 1'b0, 1'b1);
        step(f_br(5'd4, 5'd0, 1'b0, 1'b0), 4'b1100, 1'b0, 1'b1);
        step(f_br(5'd4, 5'd0, 1'b0, 1'b0), 4'b1100, 1'b0, 1'b1);
        step(f_br(5'd4, 5'd0, 1'b0, 1'b0), 4'b0000, 1'b0, 1'b1);
        drain(3);

        phase = "alu_jalr";
        step(f_alu(5'd6, 5'd1, 5'd2), 4'b0000, 1'b0, 1'b1);
        step(f_jalr(5'd1, 5'd6), 4'b1100, 1'b0, 1'b1);
        step(f_jalr(5'd1, 5'd6), 4'b0010, 1'b0, 1'b1);
        drain(3);

        phase = "mispredict";
        step(f_br(5'd2, 5'd0, 1'b1, 1'b0), 4'b0011, 1'b0, 1'b1);
        step(f_br(5'd2, 5'd0, 1'b1, 1'b1), 4'b0000, 1'b0, 1'b1);
        step(f_br(5'd2, 5'd0, 1'b0, 1'b1), 4'b0011, 1'b0, 1'b1);
        drain(1);

        phase = "mem_wait";
        step(f_mul(5'd7, 5'd1, 5'd2), 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(f_alu(5'd8, 5'd7, 5'd2), 4'b1000, 1'b1, 1'b1);
        step(f_alu(5'd8, 5'd7, 5'd2), 4'b1100, 1'b0, 1'b1);
        step(f_alu(5'd8, 5'd7, 5'd2), 4'b1100, 1'b0, 1'b1);
        step(f_alu(5'd8, 5'd7, 5'd2), 4'b0000, 1'b0, 1'b1);
        step(f_nop(), 4'b0000, 1'b1, 1'b1);
        drain(3);

        phase = "same_src";
        step(f_alu(5'd9, 5'd1, 5'd2), 4'b0000, 1'b0, 1'b1);
        step(f_br(5'd9, 5'd9, 1'b0, 1'b0), 4'b1100, 1'b0, 1'b1);
        step(f_br(5'd9, 5'd9, 1'b0, 1'b0), 4'b0000, 1'b0, 1'b1);
        step(f_load(5'd0, 5'd1), 4'b0000, 1'b0, 1'b1);
        step(f_br(5'd0, 5'd0, 1'b0, 1'b0), 4'b0000, 1'b0, 1'b1);
        drain(3);

        phase = "unused_src";
        step(f_load(5'd10, 5'd1), 4'b0000, 1'b0, 1'b1);
        begin
            instr_t i;
            i = f_alu(5'd11, 5'd10, 5'd10);
            i.u1 = 1'b0;
            i.u2 = 1'b0;
            step(i, 4'b0000, 1'b0, 1'b1);
        end
        drain(3);

        phase = "reset_mid_stall";
        step(f_load(5'd3, 5'd1), 4'b0000, 1'b0, 1'b1);
        step(f_br(5'd3, 5'd0, 1'b1, 1'b1), 4'b1100, 1'b0, 1'b1);
        step(f_br(5'd3, 5'd0, 1'b1, 1'b1), 4'b0000, 1'b0, 1'b0);
        step(f_br(5'd3, 5'd0, 1'b1, 1'b1), 4'b0000, 1'b0, 1'b1);
        step(f_jalr(5'd0, 5'd3), 4'b0010, 1'b0, 1'b1);
        drain(2);

        @(negedge clk);
        @(negedge clk);
        phase = "end";
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
